// File: rtl/cbrt_pkg.sv
// Shared definitions for the cube-root dispatcher: data widths, default job
// timeout and the dispatcher FSM state encoding.
package cbrt_pkg;

  localparam int XW          = 8;     // operand width
  localparam int RW          = 3;     // cube-root result width
  localparam int TIMEOUT_DEF = 2000;  // default max engine busy cycles per job

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RUN,
    ST_OUT
  } state_e;

endpackage

// File: rtl/cbrt_fifo.sv
// Operand buffer for the cube-root dispatcher.
// DEPTH entries of XW bits, first-in first-out, show-ahead read (dout_o is
// the current head whenever empty_o is low).
// Ports:
//   clk, rst  - clock, synchronous active-high reset (empties the buffer)
//   push_i    - write din_i this cycle
//   din_i     - operand to store
//   pop_i     - drop the head this cycle
//   dout_o    - head entry
//   full_o    - DEPTH entries held
//   empty_o   - no entries held
module cbrt_fifo
  import cbrt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [XW-1:0] din_i,
  input  logic          pop_i,
  output logic [XW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  // A push while full is still taken when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/cbrt_dispatch.sv
// Cube-root job dispatcher: buffers operands, issues them one at a time to an
// external cube-root engine, guards each job with a busy timeout and presents
// one result record per operand.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   in_valid/in_x/in_ready          - operand input handshake
//   eng_x/eng_start                 - engine operand and one-cycle start pulse
//   eng_busy/eng_result             - engine status and result
//   out_valid/out_x/out_result/
//   out_err/out_ready               - result record handshake
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no job; pop FIFO head into job register when available
// ST_ISSUE | eng_start high for this single cycle, timeout counter cleared
// ST_RUN   | wait for engine to drop busy, or abort at TIMEOUT busy cycles
// ST_OUT   | record held on out_* until downstream takes it
module cbrt_dispatch
  import cbrt_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [XW-1:0] in_x,
  output logic          in_ready,
  output logic [XW-1:0] eng_x,
  output logic          eng_start,
  input  logic          eng_busy,
  input  logic [RW-1:0] eng_result,
  output logic          out_valid,
  output logic [XW-1:0] out_x,
  output logic [RW-1:0] out_result,
  output logic          out_err,
  input  logic          out_ready
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [XW-1:0] job_q, job_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] out_x_q, out_x_d;
  logic [RW-1:0] out_res_q, out_res_d;
  logic          out_err_q, out_err_d;

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [XW-1:0] fifo_dout;

  assign in_ready = !fifo_full;

  cbrt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid && in_ready),
    .din_i   (in_x),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      job_q     <= '0;
      cnt_q     <= '0;
      out_x_q   <= '0;
      out_res_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      job_q     <= job_d;
      cnt_q     <= cnt_d;
      out_x_q   <= out_x_d;
      out_res_q <= out_res_d;
      out_err_q <= out_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    job_d     = job_q;
    cnt_d     = cnt_q;
    out_x_d   = out_x_q;
    out_res_d = out_res_q;
    out_err_d = out_err_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          job_d    = fifo_dout;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // A finished engine wins over a timeout expiring in the same cycle.
        if (!eng_busy) begin
          out_x_d   = job_q;
          out_res_d = eng_result;
          out_err_d = 1'b0;
          state_d   = ST_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            out_x_d   = job_q;
            out_res_d = '0;
            out_err_d = 1'b1;
            state_d   = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // job_q only reloads in IDLE, so eng_x stays stable from ISSUE through RUN.
  assign eng_x      = job_q;
  assign eng_start  = (state_q == ST_ISSUE);
  assign out_valid  = (state_q == ST_OUT);
  assign out_x      = out_x_q;
  assign out_result = out_res_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_cbrt_dispatch.sv
// Testbench for cbrt_dispatch with a bit-serial multiply-based cube-root
// engine model on the same clock and reset. Expected records are queued as
// operands are accepted and compared as records come out.
module tb_cbrt_dispatch;
  import cbrt_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [XW-1:0] in_x = '0;
  logic          in_ready;
  logic [XW-1:0] eng_x;
  logic          eng_start;
  logic          eng_busy;
  logic [RW-1:0] eng_result;
  logic          out_valid;
  logic [XW-1:0] out_x;
  logic [RW-1:0] out_result;
  logic          out_err;
  logic          out_ready = 1'b1;

  always #5 clk = ~clk;

  cbrt_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_x       (in_x),
    .in_ready   (in_ready),
    .eng_x      (eng_x),
    .eng_start  (eng_start),
    .eng_busy   (eng_busy),
    .eng_result (eng_result),
    .out_valid  (out_valid),
    .out_x      (out_x),
    .out_result (out_result),
    .out_err    (out_err),
    .out_ready  (out_ready)
  );

  // Engine: one result bit per busy cycle, MSB first, keep bit if trial^3 <= x.
  logic          e_busy = 1'b0;
  logic [XW-1:0] e_x = '0;
  logic [RW-1:0] e_r = '0;
  logic [1:0]    e_bit = '0;
  logic          eng_stuck = 1'b0;

  function automatic logic [RW-1:0] eng_step(input logic [RW-1:0] r, input logic [1:0] b,
                                             input logic [XW-1:0] x);
    logic [RW-1:0] t;
    t = r | (3'd1 << b);
    return (int'(t) * int'(t) * int'(t) <= int'(x)) ? t : r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      e_busy <= 1'b0;
      e_x    <= '0;
      e_r    <= '0;
      e_bit  <= '0;
    end else if (eng_start) begin
      e_busy <= 1'b1;
      e_x    <= eng_x;
      e_r    <= '0;
      e_bit  <= 2'd2;
    end else if (e_busy) begin
      e_r <= eng_step(e_r, e_bit, e_x);
      if (e_bit == 2'd0) e_busy <= 1'b0;
      else               e_bit  <= e_bit - 2'd1;
    end
  end

  assign eng_busy   = e_busy | eng_stuck;
  assign eng_result = e_r;

  // Independent reference: brute-force floor cube root.
  function automatic logic [RW-1:0] ref_cbrt(input int x);
    int r;
    r = 0;
    for (int k = 0; k < 8; k++) if (k * k * k <= x) r = k;
    return RW'(r);
  endfunction

  typedef struct {
    logic [XW-1:0] x;
    logic [RW-1:0] res;
    logic          err;
  } rec_t;

  rec_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   n_starts = 0;

  always @(posedge clk) if (eng_start) n_starts <= n_starts + 1;

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [XW-1:0] x, input logic [RW-1:0] res, input logic err,
                      output int waited);
    rec_t r;
    waited   = 0;
    in_valid = 1'b1;
    in_x     = x;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    r.x = x; r.res = res; r.err = err;
    if (in_ready) sb.push_back(r);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit to);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    to = !out_valid;
  endtask

  task automatic pop_exp(output rec_t e);
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.x = '0; e.res = '0; e.err = 1'b0; end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || eng_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: out_valid=%b eng_start=%b, want 0 0", out_valid, eng_start);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if ({out_x, out_result, out_err, eng_x} !== '0) begin
      errors++;
      $display("FAIL reset_regs: out_x=%0d out_result=%0d out_err=%b eng_x=%0d, want all 0",
               out_x, out_result, out_err, eng_x);
    end
  endtask

  task automatic test_basic();
    logic [XW-1:0] xs[3] = '{8'd27, 8'd64, 8'd125};
    logic [RW-1:0] rs[3] = '{3'd3, 3'd4, 3'd5};
    int w, s0;
    bit to;
    rec_t e;
    out_ready = 1'b1;
    s0 = n_starts;
    for (int i = 0; i < 3; i++) send(xs[i], rs[i], 1'b0, w);
    for (int i = 0; i < 3; i++) begin
      wait_out(to);
      pop_exp(e);
      checks++;
      if (to || {out_x, out_result, out_err} !== {e.x, e.res, e.err}) begin
        errors++;
        $display("FAIL basic_rec%0d: got (%0d,%0d,%0b) want (%0d,%0d,%0b) timeout=%0b",
                 i, out_x, out_result, out_err, e.x, e.res, e.err, to);
      end
      @(negedge clk);
    end
    checks++;
    if (n_starts - s0 != 3) begin
      errors++; $display("FAIL basic_starts: got %0d want 3", n_starts - s0);
    end
  endtask

  task automatic test_latency();
    int w, k;
    rec_t e;
    out_ready = 1'b1;
    send(8'd64, 3'd4, 1'b0, w);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 6) begin
      errors++; $display("FAIL latency: got %0d cycles want 6", k);
    end
    pop_exp(e);
    checks++;
    if ({out_x, out_result, out_err} !== {e.x, e.res, e.err}) begin
      errors++;
      $display("FAIL latency_rec: got (%0d,%0d,%0b) want (%0d,%0d,%0b)",
               out_x, out_result, out_err, e.x, e.res, e.err);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [XW-1:0] xs[4] = '{8'd0, 8'd8, 8'd216, 8'd255};
    logic [RW-1:0] rs[4] = '{3'd0, 3'd2, 3'd6, 3'd6};
    logic [XW-1:0] hx;
    logic [RW-1:0] hr;
    logic          he;
    int w, s1;
    bit to;
    rec_t e;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(xs[i], rs[i], 1'b0, w);
      checks++;
      if (w != 0) begin
        errors++; $display("FAIL bp_push%0d_wait: got %0d cycles want 0", i, w);
      end
    end
    wait_out(to);
    checks++;
    if (to || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_in_ready: got %b want 1 timeout=%0b", in_ready, to);
    end
    hx = out_x; hr = out_result; he = out_err; s1 = n_starts;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || {out_x, out_result, out_err} !== {hx, hr, he}) begin
        errors++;
        $display("FAIL bp_hold: got v=%b (%0d,%0d,%0b) want v=1 (%0d,%0d,%0b)",
                 out_valid, out_x, out_result, out_err, hx, hr, he);
      end
    end
    checks++;
    if (n_starts != s1) begin
      errors++; $display("FAIL bp_no_start: got %0d starts want 0", n_starts - s1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_out(to);
      pop_exp(e);
      checks++;
      if (to || {out_x, out_result, out_err} !== {e.x, e.res, e.err}) begin
        errors++;
        $display("FAIL bp_rec%0d: got (%0d,%0d,%0b) want (%0d,%0d,%0b) timeout=%0b",
                 i, out_x, out_result, out_err, e.x, e.res, e.err, to);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full();
    logic [XW-1:0] xs[5] = '{8'd1, 8'd9, 8'd30, 8'd65, 8'd126};
    logic [RW-1:0] rs[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    int w, k;
    bit to;
    rec_t e, r;
    out_ready = 1'b0;
    // One operand goes to the job register, the other four fill the FIFO.
    for (int i = 0; i < 5; i++) send(xs[i], rs[i], 1'b0, w);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_in_ready: got %b want 0", in_ready);
    end
    in_valid = 1'b1;
    in_x     = 8'd250;
    repeat (4) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_refuse: got in_ready=%b want 0", in_ready);
    end
    wait_out(to);
    pop_exp(e);
    checks++;
    if (to || {out_x, out_result, out_err} !== {e.x, e.res, e.err}) begin
      errors++;
      $display("FAIL full_rec0: got (%0d,%0d,%0b) want (%0d,%0d,%0b) timeout=%0b",
               out_x, out_result, out_err, e.x, e.res, e.err, to);
    end
    out_ready = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL full_reopen: got in_ready=%b want 1", in_ready);
    end else begin
      r.x = 8'd250; r.res = 3'd6; r.err = 1'b0;
      sb.push_back(r);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_refill: got in_ready=%b want 0", in_ready);
    end
    for (int i = 1; i < 6; i++) begin
      wait_out(to);
      pop_exp(e);
      checks++;
      if (to || {out_x, out_result, out_err} !== {e.x, e.res, e.err}) begin
        errors++;
        $display("FAIL full_rec%0d: got (%0d,%0d,%0b) want (%0d,%0d,%0b) timeout=%0b",
                 i, out_x, out_result, out_err, e.x, e.res, e.err, to);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int w, k, s0;
    bit to;
    rec_t e;
    out_ready = 1'b1;
    eng_stuck = 1'b1;
    s0 = n_starts;
    send(8'd100, 3'd0, 1'b1, w);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    // accept -> ISSUE -> RUN, then TIMEOUT busy cycles in RUN
    checks++;
    if (k != TIMEOUT + 2) begin
      errors++; $display("FAIL to_latency: got %0d cycles want %0d", k, TIMEOUT + 2);
    end
    pop_exp(e);
    checks++;
    if ({out_x, out_result, out_err} !== {e.x, e.res, e.err}) begin
      errors++;
      $display("FAIL to_rec: got (%0d,%0d,%0b) want (%0d,%0d,%0b)",
               out_x, out_result, out_err, e.x, e.res, e.err);
    end
    eng_stuck = 1'b0;
    @(negedge clk);
    checks++;
    if (n_starts - s0 != 1) begin
      errors++; $display("FAIL to_starts: got %0d want 1", n_starts - s0);
    end
    send(8'd27, 3'd3, 1'b0, w);
    wait_out(to);
    pop_exp(e);
    checks++;
    if (to || {out_x, out_result, out_err} !== {e.x, e.res, e.err}) begin
      errors++;
      $display("FAIL to_next: got (%0d,%0d,%0b) want (%0d,%0d,%0b) timeout=%0b",
               out_x, out_result, out_err, e.x, e.res, e.err, to);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int w, s0;
    bit seen, to;
    rec_t e;
    out_ready = 1'b1;
    send(8'd125, 3'd5, 1'b0, w);
    send(8'd8,   3'd2, 1'b0, w);
    send(8'd64,  3'd4, 1'b0, w);
    checks++;
    if (eng_x !== 8'd125 || eng_busy !== 1'b1) begin
      errors++; $display("FAIL rm_run: got eng_x=%0d busy=%b want 125 1", eng_x, eng_busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    s0 = n_starts;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen || n_starts != s0) begin
      errors++;
      $display("FAIL rm_quiet: got out_valid_seen=%0b starts=%0d want 0 0", seen, n_starts - s0);
    end
    checks++;
    if (in_ready !== 1'b1 || eng_start !== 1'b0) begin
      errors++; $display("FAIL rm_ctrl: got in_ready=%b eng_start=%b want 1 0", in_ready, eng_start);
    end
    checks++;
    if ({out_x, out_result, out_err, eng_x} !== '0) begin
      errors++;
      $display("FAIL rm_regs: out_x=%0d out_result=%0d out_err=%b eng_x=%0d, want all 0",
               out_x, out_result, out_err, eng_x);
    end
    send(8'd64, 3'd4, 1'b0, w);
    wait_out(to);
    pop_exp(e);
    checks++;
    if (to || {out_x, out_result, out_err} !== {e.x, e.res, e.err}) begin
      errors++;
      $display("FAIL rm_next: got (%0d,%0d,%0b) want (%0d,%0d,%0b) timeout=%0b",
               out_x, out_result, out_err, e.x, e.res, e.err, to);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [XW-1:0] x;
    int w;
    bit to;
    rec_t e;
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 3; i++) begin
        x = XW'($urandom_range(0, 255));
        send(x, ref_cbrt(int'(x)), 1'b0, w);
      end
      for (int i = 0; i < 3; i++) begin
        wait_out(to);
        pop_exp(e);
        checks++;
        if (to || {out_x, out_result, out_err} !== {e.x, e.res, e.err}) begin
          errors++;
          $display("FAIL rand_b%0d_rec%0d: got (%0d,%0d,%0b) want (%0d,%0d,%0b) timeout=%0b",
                   b, i, out_x, out_result, out_err, e.x, e.res, e.err, to);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want test sequence complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_backpressure();
    test_full();
    test_timeout();
    test_reset_mid();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_empty: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cbrt_dispatch.md
CBRT_DISPATCH -- requirements
Module: cbrt_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 2000, max engine busy cycles per job before abort.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream operand valid.
REQ-006 SHALL have port in_x  input  8  operand for cube root.
REQ-007 SHALL have port in_ready  output  1  FIFO not full; transfer when in_valid && in_ready.
REQ-008 SHALL have port eng_x  output  8  operand to cbrt engine x_i.
REQ-009 SHALL have port eng_start  output  1  one-cycle start pulse to engine.
REQ-010 SHALL have port eng_busy  input  1  engine busy.
REQ-011 SHALL have port eng_result  input  3  engine result.
REQ-012 SHALL have port out_valid  output  1  result record valid.
REQ-013 SHALL have port out_x  output  8  operand that produced the record.
REQ-014 SHALL have port out_result  output  3  cube root (0 when out_err).
REQ-015 SHALL have port out_err  output  1  job aborted by timeout.
REQ-016 SHALL have port out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.

Function
REQ-017 SHALL buffer operands in a DEPTH-entry FIFO in arrival order; in_ready = (count < DEPTH), registered-count based.
REQ-018 SHALL accept a push and a pop in the same cycle when full, count unchanged; when full, a push is refused (in_ready=0).
REQ-019 SHALL implement FSM IDLE, ISSUE, RUN, OUT.
REQ-020 IDLE: if FIFO non-empty, pop head into job register, go ISSUE; else stay.
REQ-021 ISSUE: eng_start=1 for exactly this cycle, eng_x = job operand; go RUN, clear timeout counter.
REQ-022 eng_x SHALL hold the job operand stable from ISSUE through end of RUN.
REQ-023 RUN: engine asserts busy at the edge sampling start; when eng_busy==0, capture eng_result into out_result, out_err=0, go OUT.
REQ-024 RUN: counter increments each cycle eng_busy==1; when it reaches TIMEOUT, out_result=0, out_err=1, go OUT.
REQ-025 OUT: out_valid=1 with out_x/out_result/out_err stable until out_ready; on transfer go IDLE (next job issues no earlier than 2 cycles after transfer).
REQ-026 eng_start SHALL never assert outside ISSUE; at most one job in flight.
REQ-027 Latency in_x accept (empty FIFO, idle) to out_valid = engine busy cycles + 3.
REQ-028 Counter width SHALL hold TIMEOUT (clog2(TIMEOUT+1) bits).

Reset
REQ-029 rst high SHALL, at the next edge, empty FIFO, state=IDLE, eng_start=0, eng_x=0, out_valid=0, out_x=0, out_result=0, out_err=0, counter=0.
REQ-030 in_ready SHALL be 1 in the first cycle after reset release.
REQ-031 Reset mid-job SHALL discard the in-flight job and buffered operands with no out_valid; engine is reset by the same rst.

Structure
REQ-032 Package cbrt_pkg SHALL hold the FSM state enum, operand width 8, result width 3, default TIMEOUT.
REQ-033 One sub-module, cbrt_fifo (DEPTH x 8, push/pop, full/empty, count), SHALL implement the buffer.
REQ-034 Bench SHALL instantiate cbrt_dispatch driving the existing cbrt engine (with mul) on the same clk/rst.

Verification
REQ-035 Push 27, 64, 125 back-to-back, out_ready=1 -> records (27,3,0),(64,4,0),(125,5,0) in order, one eng_start pulse each.
REQ-036 Push 0, 8, 216, 255 with out_ready=0 -> in_ready stays 1 through 4th push only if an entry popped, else 0 at full; release out_ready -> (0,0),(8,2),(216,6),(255,6) in order.
REQ-037 Full FIFO plus simultaneous push and pop -> push accepted, count stays DEPTH, no loss or duplication.
REQ-038 Engine model with eng_busy stuck high, TIMEOUT=16 -> out_valid with out_err=1, out_result=0 after 16 busy cycles; next job proceeds normally.
REQ-039 rst asserted during RUN of 125 with 2 queued -> no out_valid afterwards, in_ready=1, eng_start=0; subsequent push 64 yields (64,4,0).
REQ-040 out_ready low 10 cycles in OUT -> out_x/out_result/out_err stable, no eng_start until transfer.
